// File: rtl/aqp_esp_uart_rx.sv
// ESP32 link UART receiver: 8N1 deframer feeding the RX FIFO,
// with RTS flow control driven from the FIFO almost-full flag.
module aqp_esp_uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rxd,
   output logic       uart_rts_n,
   output logic [7:0] fifo_wrdata,
   output logic       fifo_wr_en,
   input  logic       fifo_full,
   input  logic       fifo_almost_full,
   output logic       framing_err,
   output logic       overflow,
   output logic       busy
);

   if (CLKS_PER_BIT < 4) begin : g_bad_cfg
      $error("CLKS_PER_BIT must be >= 4");
   end

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] T_ONE  = TW'(1);

   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t        state;
   logic [1:0]    sync;
   logic [1:0]    armed;
   logic          rxd_s;
   logic [TW-1:0] timer;
   logic [2:0]    bitcnt;
   logic [7:0]    shreg;
   logic          tick;

   assign rxd_s = sync[1];
   assign tick  = (timer == '0);

   // armed holds off WAIT_IDLE until the synchroniser shows the real line
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync       <= 2'b11;
         armed      <= 2'b00;
         uart_rts_n <= 1'b1;
      end else begin
         sync       <= {sync[0], uart_rxd};
         armed      <= {armed[0], 1'b1};
         uart_rts_n <= fifo_almost_full;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= WAIT_IDLE;
         timer       <= '0;
         bitcnt      <= '0;
         shreg       <= '0;
         fifo_wrdata <= '0;
         fifo_wr_en  <= 1'b0;
         framing_err <= 1'b0;
         overflow    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         fifo_wr_en  <= 1'b0;
         framing_err <= 1'b0;
         overflow    <= 1'b0;
         if (busy && !tick)
            timer <= timer - T_ONE;
         case (state)
            WAIT_IDLE: begin
               if (armed[1] && rxd_s)
                  state <= IDLE;
            end
            IDLE: begin
               if (!rxd_s) begin
                  state <= START;
                  timer <= T_HALF;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (tick) begin
                  if (!rxd_s) begin
                     state  <= DATA;
                     timer  <= T_FULL;
                     bitcnt <= '0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  shreg <= {rxd_s, shreg[7:1]};
                  timer <= T_FULL;
                  if (bitcnt == 3'd7)
                     state <= STOP;
                  else
                     bitcnt <= bitcnt + 3'd1;
               end
            end
            STOP: begin
               if (tick) begin
                  busy <= 1'b0;
                  if (rxd_s) begin
                     state <= IDLE;
                     if (fifo_full) begin
                        overflow <= 1'b1;
                     end else begin
                        fifo_wrdata <= shreg;
                        fifo_wr_en  <= 1'b1;
                     end
                  end else begin
                     framing_err <= 1'b1;
                     state       <= WAIT_IDLE;
                  end
               end
            end
            default: begin
               state <= WAIT_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
